dbuf_bbm_seq: RTL
=================

# dbuf_bbm_seq

Break-before-make sequencer for the high-side and low-side gate-drive digital buffers in the stepdown core-state path. It converts a single PWM command into two non-overlapping buffer enables, inserting a programmable dead time at every transition and enforcing a minimum on-time. It also latches faults so that both buffers are forced off. The block sits between the PWM/control logic and the gate-drive `dbuf` instances.

## Interface
Parameters:
- `DT_HL`, 4: dead-time cycles from high-side off to low-side on. Range 1..255.
- `DT_LH`, 4: dead-time cycles from low-side off to high-side on. Range 1..255.
- `MIN_ON`, 2: minimum cycles either side stays on once entered. Range 1..255.

Ports:
- `CELCLK`  in  1  block clock. Single clock domain.
- `CELRST`  in  1  reset. Synchronous, active-high.
- `CELV`  in  1  supply pin. No logic function.
- `CELG`  in  1  ground pin. No logic function.
- `SUB`  in  1  substrate pin. No logic function.
- `en`  in  1  converter enable. Already synchronized to `CELCLK`.
- `pwm`  in  1  switching command: 1 = high side on, 0 = low side on. Already synchronized.
- `fault`  in  1  fault request. Level-sensitive and synchronized.
- `hs_on`  out  1  high-side buffer enable. Registered.
- `ls_on`  out  1  low-side buffer enable. Registered.
- `fault_lat`  out  1  latched fault indicator. Registered.
- `state`  out  3  current FSM state, for debug.

## Operation
- FSM states and encodings: OFF=0, DLH=1, HS=2, DHL=3, LS=4, FLT=5.
- `cnt` is an 8-bit counter that clears to 0 on every state entry, increments each cycle in the state, and saturates at 255.
- Outputs decode the registered state:
  - `hs_on` = (state==HS).
  - `ls_on` = (state==LS).
  - `fault_lat` = (state==FLT).
- Transition priority per cycle: `fault` first, then `!en`, then normal transitions.
  - `fault`=1 in any state goes to FLT.
  - `en`=0 in any non-FLT state goes to OFF.
- Normal transitions:
  - OFF, with `en`=1: go to DLH if `pwm`=1, else DHL.
  - DLH: when `cnt`==DT_LH-1, go to HS if `pwm`=1, else LS.
  - DHL: when `cnt`==DT_HL-1, go to HS if `pwm`=1, else LS.
    - A `pwm` reversal during dead time is allowed; both buffers are already off.
  - HS: when `pwm`=0 and `cnt`>=MIN_ON-1, go to DHL. Otherwise hold.
  - LS: when `pwm`=1 and `cnt`>=MIN_ON-1, go to DLH. Otherwise hold.
  - FLT: sticky. Exit to OFF only when `fault`=0 and `en`=0 in the same cycle.
- Invariant: `hs_on` & `ls_on` is never 1. Every HS↔LS path passes through a dead state.
- Reset values: state=OFF, `cnt`=0, `hs_on`=0, `ls_on`=0, `fault_lat`=0.
- Reset mid-operation takes effect at the next edge: all outputs go to 0, with no dead-time wait.

## Timing
- Inputs are sampled on the `CELCLK` rising edge. Outputs change on that same edge.
- `pwm` falling in HS with min-on met: `hs_on` drops 1 edge later. `ls_on` rises exactly DT_HL cycles after `hs_on` drops.
- `pwm` rising in LS with min-on met: `ls_on` drops 1 edge later. `hs_on` rises exactly DT_LH cycles after `ls_on` drops.
- Start-up from OFF with `en`=1 and `pwm`=1: `hs_on` rises DT_LH+1 edges after `en` is sampled.
- A `pwm` pulse shorter than MIN_ON cycles after entering HS or LS is stretched to MIN_ON cycles. It is not lost while the level persists; only the current level is evaluated.
- `fault` or `!en`: both enables go to 0 one edge after sampling. There is no dead time on shutdown.
- With `fault` and `en` deasserted in the same cycle, FLT→OFF takes 1 edge. Restart then follows the OFF rules.

## Test plan
1. Reset, then hold `CELRST`=1 for 3 cycles with `en`=1 and `pwm`=1.
   - Expect `hs_on`=`ls_on`=0, `state`=0 throughout.
   - Release reset: `hs_on` rises 5 edges later with DT_LH=4.
2. With DT_HL=4, DT_LH=3, MIN_ON=2, toggle `pwm` with period 20 and 50% duty.
   - Expect `hs_on` low for exactly 4 cycles before each `ls_on` rise.
   - Expect `ls_on` low for exactly 3 cycles before each `hs_on` rise.
   - Expect no overlap at any cycle.
3. In HS, drive `pwm` to 0 for a single cycle on the entry cycle, with MIN_ON=4.
   - Expect `hs_on` held for 4 cycles, then DHL only if `pwm` is still 0. Otherwise stay in HS.
4. Enter DHL, then raise `pwm` to 1 during dead time.
   - Expect `state` DHL→HS after DT_HL cycles and `ls_on` never asserted.
5. Assert `fault` for 1 cycle during HS.
   - Expect `hs_on`=0 next edge and `fault_lat`=1, held with `en`=1.
   - Drop `en`: `fault_lat`=0 next edge and `state`=OFF.
6. Apply `CELRST` mid-LS while `pwm` is toggling.
   - Expect `ls_on`=0 next edge and `cnt`=0.
   - After release, normal start-up from OFF.

Source files
------------

// File: rtl/dbuf_bbm_seq.sv
// rtl/dbuf_bbm_seq.sv - break-before-make sequencer for high/low-side gate-drive buffer enables
// One PWM command becomes two non-overlapping enables with dead time, minimum on-time and a sticky fault.
module dbuf_bbm_seq #(
   parameter int DT_HL  = 4,
   parameter int DT_LH  = 4,
   parameter int MIN_ON = 2
) (
   input  logic       CELCLK,
   input  logic       CELRST,
   input  logic       CELV,
   input  logic       CELG,
   input  logic       SUB,
   input  logic       en,
   input  logic       pwm,
   input  logic       fault,
   output logic       hs_on,
   output logic       ls_on,
   output logic       fault_lat,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_OFF = 3'd0,
      ST_DLH = 3'd1,
      ST_HS  = 3'd2,
      ST_DHL = 3'd3,
      ST_LS  = 3'd4,
      ST_FLT = 3'd5
   } state_t;

   localparam logic [7:0] HL_LAST = 8'(DT_HL - 1);
   localparam logic [7:0] LH_LAST = 8'(DT_LH - 1);
   localparam logic [7:0] ON_LAST = 8'(MIN_ON - 1);

   // Power and substrate pins carry no logic.
   logic unused_pins;
   assign unused_pins = CELV & CELG & SUB;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       hs_on_q, hs_on_d;
   logic       ls_on_q, ls_on_d;
   logic       fault_lat_q, fault_lat_d;

   always_comb begin
      state_d = state_q;
      if (fault) begin
         state_d = ST_FLT;
      end else if (!en) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF: state_d = pwm ? ST_DLH : ST_DHL;
            ST_DLH: if (cnt_q == LH_LAST) state_d = pwm ? ST_HS : ST_LS;
            ST_DHL: if (cnt_q == HL_LAST) state_d = pwm ? ST_HS : ST_LS;
            ST_HS:  if (!pwm && (cnt_q >= ON_LAST)) state_d = ST_DHL;
            ST_LS:  if (pwm && (cnt_q >= ON_LAST)) state_d = ST_DLH;
            ST_FLT: state_d = ST_FLT;
            default: state_d = ST_OFF;
         endcase
      end

      // Counter restarts on every state change and saturates otherwise.
      if (state_d != state_q) begin
         cnt_d = 8'd0;
      end else if (cnt_q == 8'hFF) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end

      hs_on_d     = (state_d == ST_HS);
      ls_on_d     = (state_d == ST_LS);
      fault_lat_d = (state_d == ST_FLT);
   end

   always_ff @(posedge CELCLK) begin
      if (CELRST) begin
         state_q     <= ST_OFF;
         cnt_q       <= 8'd0;
         hs_on_q     <= 1'b0;
         ls_on_q     <= 1'b0;
         fault_lat_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hs_on_q     <= hs_on_d;
         ls_on_q     <= ls_on_d;
         fault_lat_q <= fault_lat_d;
      end
   end

   assign hs_on     = hs_on_q;
   assign ls_on     = ls_on_q;
   assign fault_lat = fault_lat_q;
   assign state     = state_q;

endmodule
